context_mem_scheduler: RTL

//  Owns the single-port context memory (A/B/C/N words, one per context Q) and schedules all accesses to it.
//  At start-up it sweeps every context to its initial value.
//  It then arbitrates per-pixel context reads against delayed context write-backs, using a 1-entry write buffer.

---
 rtl/context_mem_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/context_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : context_mem_scheduler
// Description : Owns the single-port context RAM: start-up init sweep, then
//               read/write-back arbitration with a 1-entry write buffer and
//               RAW forwarding.
// Revision    : 1.0
// ============================================================================
module context_mem_scheduler #(
    parameter int               Q_length   = 9,
    parameter int               CTX_W      = 32,
    parameter int               NUM_CTX    = 365,
    parameter logic [CTX_W-1:0] INIT_VALUE = 'h00040001
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_req,
    output logic                init_done,
    input  logic                rd_req,
    input  logic [Q_length-1:0] rd_q,
    output logic                rd_ready,
    output logic                rd_valid,
    output logic [CTX_W-1:0]    rd_data,
    output logic                rd_bypass,
    input  logic                wr_req,
    input  logic [Q_length-1:0] wr_q,
    input  logic [CTX_W-1:0]    wr_data,
    output logic                wr_ready,
    output logic                idle,
    output logic [Q_length-1:0] mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [CTX_W-1:0]    mem_wdata,
    input  logic [CTX_W-1:0]    mem_rdata
);

    localparam logic [Q_length-1:0] c_last_ctx = Q_length'(NUM_CTX - 1);

    typedef enum logic [1:0] {
        S_PRE  = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [Q_length-1:0] r_cnt;
    logic                r_wb_valid;
    logic [Q_length-1:0] r_wb_q;
    logic [CTX_W-1:0]    r_wb_data;
    logic                r_rd_valid;
    logic                r_rd_bypass;
    logic [CTX_W-1:0]    r_rd_hold;

    logic             w_run;
    logic             w_active;
    logic             w_hit_wr;
    logic             w_hit_wb;
    logic             w_rd_ready;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_bypass;
    logic             w_mem_rd;
    logic             w_drain;
    logic [CTX_W-1:0] w_fwd_data;

    assign w_run    = (r_state == S_RUN);
    // The cycle that restarts INIT accepts nothing and leaves the port idle.
    assign w_active = w_run && !init_req;

    assign w_hit_wr   = wr_req && (wr_q == rd_q);
    assign w_hit_wb   = r_wb_valid && (r_wb_q == rd_q);
    assign w_rd_ready = w_active && (!(r_wb_valid && wr_req) || w_hit_wr || w_hit_wb);
    assign w_rd_acc   = rd_req && w_rd_ready;
    assign w_wr_acc   = wr_req && w_active;
    assign w_bypass   = w_rd_acc && (w_hit_wr || w_hit_wb);
    assign w_mem_rd   = w_rd_acc && !(w_hit_wr || w_hit_wb);
    assign w_drain    = w_active && r_wb_valid && !w_mem_rd;
    assign w_fwd_data = w_hit_wr ? wr_data : r_wb_data;

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == S_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = r_cnt;
            mem_wdata = INIT_VALUE;
        end else if (w_mem_rd) begin
            mem_re   = 1'b1;
            mem_addr = rd_q;
        end else if (w_drain) begin
            mem_we    = 1'b1;
            mem_addr  = r_wb_q;
            mem_wdata = r_wb_data;
        end
    end

    assign init_done = w_run;
    assign idle      = w_run && !r_wb_valid;
    assign rd_ready  = w_rd_ready;
    assign wr_ready  = w_active;
    assign rd_valid  = r_rd_valid;
    assign rd_bypass = r_rd_bypass;
    // RAM data is live only in the valid cycle; otherwise the last word is held.
    assign rd_data   = (r_rd_valid && !r_rd_bypass) ? mem_rdata : r_rd_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_PRE;
            r_cnt       <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_q      <= '0;
            r_wb_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_bypass <= 1'b0;
            r_rd_hold   <= '0;
        end else begin
            case (r_state)
                S_PRE: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                end
                S_INIT: begin
                    if (r_cnt == c_last_ctx) begin
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (init_req) begin
                        r_state    <= S_INIT;
                        r_cnt      <= '0;
                        r_wb_valid <= 1'b0;
                    end else if (w_wr_acc) begin
                        r_wb_valid <= 1'b1;
                        r_wb_q     <= wr_q;
                        r_wb_data  <= wr_data;
                    end else if (w_drain) begin
                        r_wb_valid <= 1'b0;
                    end
                end
                default: r_state <= S_PRE;
            endcase

            r_rd_valid  <= w_rd_acc;
            r_rd_bypass <= w_bypass;
            if (w_bypass) begin
                r_rd_hold <= w_fwd_data;
            end else if (r_rd_valid && !r_rd_bypass) begin
                r_rd_hold <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
